// File: rtl/step_responder.sv
// step_responder: responder end of the step-sequencer handshake.
// Optional watchdog build: define STEP_RESP_TIMEOUT_EN.
module step_responder #(
  parameter int ACK_LATENCY    = 3,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_step,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_step,
  output logic                 rsp_err,
  output logic [CNT_WIDTH-1:0] seq_count,
  output logic                 busy,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_DELAY,
    S_RESP
  } state_t;

  localparam logic [7:0] LAT = 8'(ACK_LATENCY);

  if (ACK_LATENCY < 0 || ACK_LATENCY > 255) begin : g_lat_chk
    $error("step_responder: ACK_LATENCY must be 0..255");
  end

  state_t     state;
  state_t     state_n;
  logic [7:0] cnt;
  logic [1:0] exp_step;
  logic       accept;
  logic       step_ok;
  logic       wd_fire;

  assign accept  = req_valid && req_ready;
  assign step_ok = (req_step == exp_step);

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      S_WAIT:  if (accept)       state_n = S_DELAY;
      S_DELAY: if (cnt == LAT)   state_n = S_RESP;
      S_RESP:  if (rsp_ready)    state_n = S_WAIT;
      default:                   state_n = S_WAIT;
    endcase
  end

  // state register with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_WAIT;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == S_WAIT);
      rsp_valid <= (state_n == S_RESP);
      busy      <= (state_n != S_WAIT);
    end
  end

  // latency counter, runs only while the delay continues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (state == S_DELAY && state_n == S_DELAY) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= 8'd0;
    end
  end

  // capture response, track expected step and sequence count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_step  <= 2'd0;
      rsp_err   <= 1'b0;
      exp_step  <= 2'd0;
      seq_count <= '0;
    end else if (accept) begin
      rsp_step <= req_step;
      rsp_err  <= !step_ok;
      if (step_ok) begin
        exp_step <= exp_step + 2'd1;
        if (req_step == 2'd3) begin
          seq_count <= seq_count + CNT_WIDTH'(1);
        end
      end else begin
        exp_step <= 2'd0;
      end
    end else if (wd_fire) begin
      exp_step <= 2'd0;
    end
  end

`ifdef STEP_RESP_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd_cnt;
  logic           wd_arm;

  assign wd_arm  = (state == S_WAIT) && (exp_step != 2'd0);
  assign wd_fire = !accept && wd_arm && (wd_cnt == WD_LAST);

  // watchdog on a stalled partial sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= wd_fire;
      if (accept || wd_fire || !wd_arm) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WDW'(1);
      end
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_step_responder.sv
// tb_step_responder: randomized self-checking bench for step_responder.
// Instance 0: ACK_LATENCY=3, CNT_WIDTH=8. Instance 1: ACK_LATENCY=0, CNT_WIDTH=2.
module tb_step_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid [2];
  logic       req_ready [2];
  logic [1:0] req_step  [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [1:0] rsp_step  [2];
  logic       rsp_err   [2];
  logic       busy      [2];
  logic       timeout   [2];
  logic [7:0] seq_a;
  logic [1:0] seq_b;

  int total = 0;
  int bad   = 0;
  int exp_m [2];
  int seq_m [2];
  int lat_m [2] = '{3, 0};
  int mod_m [2] = '{256, 4};

  always #5 clk = ~clk;

  step_responder #(.ACK_LATENCY(3), .CNT_WIDTH(8)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_step(req_step[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_step(rsp_step[0]), .rsp_err(rsp_err[0]),
    .seq_count(seq_a), .busy(busy[0]), .timeout(timeout[0])
  );

  step_responder #(.ACK_LATENCY(0), .CNT_WIDTH(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_step(req_step[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_step(rsp_step[1]), .rsp_err(rsp_err[1]),
    .seq_count(seq_b), .busy(busy[1]), .timeout(timeout[1])
  );

  function automatic int get_seq(input int s);
    return (s == 0) ? int'(seq_a) : int'(seq_b);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_m[i] = 0;
      seq_m[i] = 0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_step[i]  = 2'd0;
      rsp_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (req_ready[i] !== 1'b1 || rsp_valid[i] !== 1'b0 ||
          busy[i] !== 1'b0 || rsp_step[i] !== 2'd0 ||
          rsp_err[i] !== 1'b0 || timeout[i] !== 1'b0 ||
          get_seq(i) != 0) begin
        bad++;
        $display("FAIL reset_vals dut=%0d rdy=%b vld=%b busy=%b step=%0d err=%b to=%b seq=%0d want 1,0,0,0,0,0,0",
                 i, req_ready[i], rsp_valid[i], busy[i], rsp_step[i],
                 rsp_err[i], timeout[i], get_seq(i));
      end
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int s, input int step, input int bp,
                        input bit pre, input int nstep);
    int k;
    bit err_m;
    rsp_ready[s] = (bp == 0);
    req_valid[s] = 1'b1;
    req_step[s]  = 2'(step);
    k = 0;
    while (req_ready[s] !== 1'b1 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    total++;
    if (k >= 200) begin
      bad++;
      $display("FAIL ready_wait dut=%0d req_ready never rose", s);
    end
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    err_m = (step != exp_m[s]);
    if (!err_m) begin
      exp_m[s] = (exp_m[s] + 1) % 4;
      if (step == 3) seq_m[s] = (seq_m[s] + 1) % mod_m[s];
    end else begin
      exp_m[s] = 0;
    end
    total++;
    if (busy[s] !== 1'b1 || req_ready[s] !== 1'b0) begin
      bad++;
      $display("FAIL accept dut=%0d busy=%b rdy=%b want 1,0", s, busy[s], req_ready[s]);
    end
    total++;
    if (get_seq(s) != seq_m[s]) begin
      bad++;
      $display("FAIL seq_count dut=%0d got=%0d want=%0d", s, get_seq(s), seq_m[s]);
    end
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (rsp_valid[s] !== 1'b1 && k < 300);
    total++;
    if (k != lat_m[s] + 1) begin
      bad++;
      $display("FAIL latency dut=%0d got=%0d want=%0d", s, k, lat_m[s] + 1);
    end
    total++;
    if (rsp_step[s] !== 2'(step) || rsp_err[s] !== err_m) begin
      bad++;
      $display("FAIL rsp dut=%0d step=%0d err=%b want %0d,%b",
               s, rsp_step[s], rsp_err[s], step, err_m);
    end
    if (bp > 0) begin
      if (pre) begin
        req_valid[s] = 1'b1;
        req_step[s]  = 2'(nstep);
      end
      for (int i = 0; i < bp; i++) begin
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid[s] !== 1'b1 || rsp_step[s] !== 2'(step) ||
            rsp_err[s] !== err_m || req_ready[s] !== 1'b0 ||
            busy[s] !== 1'b1) begin
          bad++;
          $display("FAIL hold dut=%0d cyc=%0d vld=%b step=%0d err=%b rdy=%b busy=%b",
                   s, i, rsp_valid[s], rsp_step[s], rsp_err[s],
                   req_ready[s], busy[s]);
        end
      end
      rsp_ready[s] = 1'b1;
    end
    @(posedge clk);
    #1;
    total++;
    if (rsp_valid[s] !== 1'b0 || req_ready[s] !== 1'b1 || busy[s] !== 1'b0) begin
      bad++;
      $display("FAIL handshake dut=%0d vld=%b rdy=%b busy=%b want 0,1,0",
               s, rsp_valid[s], req_ready[s], busy[s]);
    end
  endtask

  task automatic test_reset();
    bit ok;
    apply_reset();
    req_valid[0] = 1'b1;
    req_step[0]  = 2'd0;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0 ||
        rsp_step[0] !== 2'd0 || rsp_err[0] !== 1'b0 || seq_a !== 8'd0) begin
      bad++;
      $display("FAIL async_reset rdy=%b vld=%b busy=%b step=%0d err=%b seq=%0d",
               req_ready[0], rsp_valid[0], busy[0], rsp_step[0], rsp_err[0], seq_a);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL discard rsp_valid seen or req_ready low after reset, want 0/1");
    end
    do_txn(0, 1, 0, 1'b0, 0);
    total++;
    if (rsp_err[0] !== 1'b1) begin
      bad++;
      $display("FAIL exp_after_reset err=%b want 1", rsp_err[0]);
    end
  endtask

  task automatic test_in_order();
    for (int st = 0; st < 4; st++) do_txn(0, st, 0, 1'b0, 0);
    total++;
    if (seq_a !== 8'd1) begin
      bad++;
      $display("FAIL in_order_seq got=%0d want=1", seq_a);
    end
  endtask

  task automatic test_out_of_order();
    int steps [7] = '{0, 2, 1, 0, 1, 2, 3};
    int errs  [7] = '{0, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      do_txn(0, steps[i], 0, 1'b0, 0);
      total++;
      if (rsp_err[0] !== 1'(errs[i])) begin
        bad++;
        $display("FAIL ooo_err idx=%0d got=%b want=%0d", i, rsp_err[0], errs[i]);
      end
    end
    total++;
    if (seq_a !== 8'd2) begin
      bad++;
      $display("FAIL ooo_seq got=%0d want=2", seq_a);
    end
  endtask

  task automatic test_backpressure();
    int first;
    int nxt;
    first = exp_m[0];
    nxt   = (first + 1) % 4;
    do_txn(0, first, 10, 1'b1, nxt);
    do_txn(0, nxt, 0, 1'b0, 0);
  endtask

  task automatic test_random(input int s, input int n);
    int step;
    for (int i = 0; i < n; i++) begin
      step = ($urandom_range(0, 9) < 7) ? exp_m[s] : int'($urandom_range(0, 3));
      do_txn(s, step, int'($urandom_range(0, 3)), 1'b0, 0);
    end
  endtask

  task automatic test_wrap();
    int want [5] = '{1, 2, 3, 0, 1};
    for (int q = 0; q < 5; q++) begin
      for (int st = 0; st < 4; st++) do_txn(1, st, 0, 1'b0, 0);
      total++;
      if (int'(seq_b) != want[q]) begin
        bad++;
        $display("FAIL wrap seq=%0d got=%0d want=%0d", q, seq_b, want[q]);
      end
    end
  endtask

  task automatic test_timeout();
    int pulses;
    int want;
    apply_reset();
    do_txn(0, 0, 0, 1'b0, 0);
    do_txn(0, 1, 0, 1'b0, 0);
    pulses = 0;
    for (int i = 0; i < 90; i++) begin
      @(posedge clk);
      #1;
      if (timeout[0] === 1'b1) pulses++;
    end
`ifdef STEP_RESP_TIMEOUT_EN
    want = 1;
    exp_m[0] = 0;
`else
    want = 0;
`endif
    total++;
    if (pulses != want) begin
      bad++;
      $display("FAIL timeout_pulses got=%0d want=%0d", pulses, want);
    end
    do_txn(0, 2, 0, 1'b0, 0);
    total++;
    if (rsp_err[0] !== 1'(want)) begin
      bad++;
      $display("FAIL timeout_err got=%b want=%0d", rsp_err[0], want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_step[i]  = 2'd0;
      rsp_ready[i] = 1'b1;
    end
    model_reset();
    test_reset();
    test_in_order();
    test_out_of_order();
    test_backpressure();
    test_random(0, 30);
    test_wrap();
    test_random(1, 30);
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
